// File: rtl/alarm_ctrl_if.sv
// Alarm controller bundle: clock-module time, user controls, and alarm status/display outputs.
// Latency: none (signal grouping only).
// Backpressure: none; every control is a level or single-cycle pulse accepted each cycle.
interface alarm_ctrl_if;
   logic        alarm_ctrl_sec_tick;
   logic [15:0] alarm_ctrl_time;
   logic        alarm_ctrl_set;
   logic        alarm_ctrl_sel;
   logic        alarm_ctrl_inc;
   logic        alarm_ctrl_dec;
   logic        alarm_ctrl_arm;
   logic        alarm_ctrl_snooze;
   logic        alarm_ctrl_stop;
   logic [15:0] alarm_ctrl_alarm_time;
   logic [15:0] alarm_ctrl_disp;
   logic        alarm_ctrl_ring;
   logic [1:0]  alarm_ctrl_state;

   // Master drives time and user controls, observes alarm status.
   modport master (
      output alarm_ctrl_sec_tick, alarm_ctrl_time, alarm_ctrl_set, alarm_ctrl_sel,
             alarm_ctrl_inc, alarm_ctrl_dec, alarm_ctrl_arm, alarm_ctrl_snooze,
             alarm_ctrl_stop,
      input  alarm_ctrl_alarm_time, alarm_ctrl_disp, alarm_ctrl_ring, alarm_ctrl_state
   );

   // Slave is the alarm controller itself.
   modport slave (
      input  alarm_ctrl_sec_tick, alarm_ctrl_time, alarm_ctrl_set, alarm_ctrl_sel,
             alarm_ctrl_inc, alarm_ctrl_dec, alarm_ctrl_arm, alarm_ctrl_snooze,
             alarm_ctrl_stop,
      output alarm_ctrl_alarm_time, alarm_ctrl_disp, alarm_ctrl_ring, alarm_ctrl_state
   );
endinterface

// File: rtl/alarm_ctrl.sv
// Alarm controller: stores the BCD alarm time, compares against clock time, sequences arm/ring/snooze/stop, muxes display.
// Latency: all outputs registered; inputs sampled at edge N are reflected in outputs from edge N.
// Backpressure: none; inc/dec/snooze/stop/sec_tick pulses are consumed in the cycle they are presented.
module alarm_ctrl #(
   parameter int unsigned RING_SEC   = 60,
   parameter int unsigned SNOOZE_SEC = 300
) (
   input  logic         alarm_ctrl_clk,
   input  logic         alarm_ctrl_rst,
   alarm_ctrl_if.slave  bus
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'b00,
      ST_ARMED   = 2'b01,
      ST_RINGING = 2'b10,
      ST_SNOOZE  = 2'b11
   } state_t;

   // Terminal counts: the tick that finds the counter here ends the interval.
   localparam logic [7:0] RING_LAST   = 8'(RING_SEC - 1);
   localparam logic [9:0] SNOOZE_LAST = 10'(SNOOZE_SEC - 1);

   state_t      state_q, state_nxt;
   logic [7:0]  ring_cnt_q, ring_cnt_nxt;
   logic [9:0]  snz_cnt_q, snz_cnt_nxt;
   logic        fired_q, fired_nxt;
   logic        fire;
   logic        match;
   logic [15:0] alarm_q, alarm_nxt;
   logic [15:0] disp_q;
   logic        ring_q;

   // BCD hours +1, 23 wraps to 00.
   function automatic logic [7:0] hour_inc(input logic [7:0] h);
      logic [7:0] r;
      if (h == 8'h23)
         r = 8'h00;
      else if (h[3:0] == 4'd9)
         r = {h[7:4] + 4'd1, 4'd0};
      else
         r = {h[7:4], h[3:0] + 4'd1};
      return r;
   endfunction

   // BCD hours -1, 00 wraps to 23.
   function automatic logic [7:0] hour_dec(input logic [7:0] h);
      logic [7:0] r;
      if (h == 8'h00)
         r = 8'h23;
      else if (h[3:0] == 4'd0)
         r = {h[7:4] - 4'd1, 4'd9};
      else
         r = {h[7:4], h[3:0] - 4'd1};
      return r;
   endfunction

   // BCD minutes +1, 59 wraps to 00.
   function automatic logic [7:0] min_inc(input logic [7:0] m);
      logic [7:0] r;
      if (m[3:0] == 4'd9)
         r = {(m[7:4] == 4'd5) ? 4'd0 : m[7:4] + 4'd1, 4'd0};
      else
         r = {m[7:4], m[3:0] + 4'd1};
      return r;
   endfunction

   // BCD minutes -1, 00 wraps to 59.
   function automatic logic [7:0] min_dec(input logic [7:0] m);
      logic [7:0] r;
      if (m[3:0] == 4'd0)
         r = {(m[7:4] == 4'd0) ? 4'd5 : m[7:4] - 4'd1, 4'd9};
      else
         r = {m[7:4], m[3:0] - 4'd1};
      return r;
   endfunction

   // Alarm-time editing: one field per pulse, no carry, simultaneous inc+dec cancels.
   always_comb begin
      alarm_nxt = alarm_q;
      if (bus.alarm_ctrl_set && (bus.alarm_ctrl_inc != bus.alarm_ctrl_dec)) begin
         if (bus.alarm_ctrl_sel)
            alarm_nxt[15:8] = bus.alarm_ctrl_inc ? hour_inc(alarm_q[15:8]) : hour_dec(alarm_q[15:8]);
         else
            alarm_nxt[7:0]  = bus.alarm_ctrl_inc ? min_inc(alarm_q[7:0]) : min_dec(alarm_q[7:0]);
      end
   end

   // Compare uses the stored alarm, so an edit lands on the following compare.
   assign match = (bus.alarm_ctrl_time == alarm_q);

   // State machine next-state and counter updates; arm=0 beats stop beats snooze beats tick.
   always_comb begin
      state_nxt    = state_q;
      ring_cnt_nxt = ring_cnt_q;
      snz_cnt_nxt  = snz_cnt_q;
      fire         = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.alarm_ctrl_arm && !bus.alarm_ctrl_set)
               state_nxt = ST_ARMED;
         end
         ST_ARMED: begin
            if (!bus.alarm_ctrl_arm) begin
               state_nxt = ST_IDLE;
            end else if (match && !fired_q && !bus.alarm_ctrl_set) begin
               state_nxt    = ST_RINGING;
               ring_cnt_nxt = 8'd0;
               fire         = 1'b1;
            end
         end
         ST_RINGING: begin
            if (!bus.alarm_ctrl_arm) begin
               state_nxt = ST_IDLE;
            end else if (bus.alarm_ctrl_stop) begin
               state_nxt = ST_ARMED;
            end else if (bus.alarm_ctrl_snooze) begin
               state_nxt   = ST_SNOOZE;
               snz_cnt_nxt = 10'd0;
            end else if (bus.alarm_ctrl_sec_tick) begin
               if (ring_cnt_q == RING_LAST)
                  state_nxt = ST_ARMED;
               else
                  ring_cnt_nxt = ring_cnt_q + 8'd1;
            end
         end
         ST_SNOOZE: begin
            if (!bus.alarm_ctrl_arm) begin
               state_nxt = ST_IDLE;
            end else if (bus.alarm_ctrl_stop) begin
               state_nxt = ST_ARMED;
            end else if (bus.alarm_ctrl_sec_tick) begin
               if (snz_cnt_q == SNOOZE_LAST) begin
                  state_nxt    = ST_RINGING;
                  ring_cnt_nxt = 8'd0;
               end else begin
                  snz_cnt_nxt = snz_cnt_q + 10'd1;
               end
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Fired blocks a second trigger until the time leaves the matching minute.
   always_comb begin
      fired_nxt = 1'b0;
      if (match)
         fired_nxt = fired_q | fire;
   end

   // State register with synchronous reset.
   always_ff @(posedge alarm_ctrl_clk) begin
      if (alarm_ctrl_rst)
         state_q <= ST_IDLE;
      else
         state_q <= state_nxt;
   end

   // Counters, fired flag, alarm time and registered outputs.
   always_ff @(posedge alarm_ctrl_clk) begin
      if (alarm_ctrl_rst) begin
         ring_cnt_q <= 8'd0;
         snz_cnt_q  <= 10'd0;
         fired_q    <= 1'b0;
         alarm_q    <= 16'h0000;
         disp_q     <= 16'h0000;
         ring_q     <= 1'b0;
      end else begin
         ring_cnt_q <= ring_cnt_nxt;
         snz_cnt_q  <= snz_cnt_nxt;
         fired_q    <= fired_nxt;
         alarm_q    <= alarm_nxt;
         disp_q     <= bus.alarm_ctrl_set ? alarm_nxt : bus.alarm_ctrl_time;
         ring_q     <= (state_nxt == ST_RINGING);
      end
   end

   assign bus.alarm_ctrl_state      = state_q;
   assign bus.alarm_ctrl_ring       = ring_q;
   assign bus.alarm_ctrl_alarm_time = alarm_q;
   assign bus.alarm_ctrl_disp       = disp_q;

endmodule

// File: doc/alarm_ctrl.md
# alarm_ctrl

Alarm controller for the alarm clock. It holds the user-programmed alarm time and compares it against the running clock-module time. A state machine sequences arm, ring, snooze and stop, and the block selects whether the clock time or the alarm time goes to the 7-segment display path. It sits between the clock module's 16-bit BCD output and the bcd_ctrl display input.

## Interface
Parameters:
- RING_SEC, 60, seconds the alarm rings before auto-timeout (1..255)
- SNOOZE_SEC, 300, snooze duration in seconds (1..1023)

Ports:
- alarm_ctrl_clk  in  1  system clock; single clock domain
- alarm_ctrl_rst  in  1  synchronous, active-high reset
- alarm_ctrl_sec_tick  in  1  one-cycle pulse once per second, synchronous to alarm_ctrl_clk
- alarm_ctrl_time  in  16  current clock time, BCD: [15:12] hours tens, [11:8] hours ones, [7:4] minutes tens, [3:0] minutes ones
- alarm_ctrl_set  in  1  level; 1 = alarm edit mode
- alarm_ctrl_sel  in  1  field select in edit mode; 1 = hours, 0 = minutes
- alarm_ctrl_inc  in  1  one-cycle pulse; increment selected field
- alarm_ctrl_dec  in  1  one-cycle pulse; decrement selected field
- alarm_ctrl_arm  in  1  level; alarm enable switch
- alarm_ctrl_snooze  in  1  one-cycle pulse; snooze request
- alarm_ctrl_stop  in  1  one-cycle pulse; stop request
- alarm_ctrl_alarm_time  out  16  stored alarm time, same BCD format
- alarm_ctrl_disp  out  16  display value to bcd_ctrl
- alarm_ctrl_ring  out  1  1 while ringing
- alarm_ctrl_state  out  2  FSM state: 00 IDLE, 01 ARMED, 10 RINGING, 11 SNOOZE

## Operation
- All outputs are registered.
- Reset values: state IDLE, ring 0, alarm_time 16'h0000, disp 16'h0000, both counters 0, fired flag 0.
- Edit mode (set=1, accepted in any state):
  - inc/dec adjust the selected field in BCD.
  - Hours wrap 23→00 on inc and 00→23 on dec.
  - Minutes wrap 59→00 on inc and 00→59 on dec.
  - No carry between fields.
  - inc and dec asserted in the same cycle: no change.
  - inc/dec are ignored when set=0.
- Display: disp = alarm_time when set=1, otherwise alarm_ctrl_time.
- match = (alarm_ctrl_time == alarm_time).
- fired flag:
  - Set on the edge that enters RINGING from ARMED.
  - Cleared on any edge where match=0.
  - Prevents re-triggering within the same matching minute.
- FSM transitions, evaluated every edge; priority: arm=0 > stop > snooze > timeout/expiry.
  - IDLE: arm=1 and set=0 → ARMED.
  - ARMED:
    - arm=0 → IDLE.
    - match=1, fired=0, set=0 → RINGING; ring counter loaded with 0.
  - RINGING:
    - arm=0 → IDLE.
    - stop → ARMED.
    - snooze → SNOOZE; snooze counter loaded with 0.
    - sec_tick with ring count = RING_SEC-1 → ARMED (timeout).
    - Any other sec_tick: ring count +1.
  - SNOOZE:
    - arm=0 → IDLE.
    - stop → ARMED.
    - sec_tick with snooze count = SNOOZE_SEC-1 → RINGING; ring counter reset to 0.
    - Any other sec_tick: snooze count +1.
    - A snooze pulse while in SNOOZE is ignored.
- ring = 1 exactly when state = RINGING.
- Counter widths: 8 bits (ring), 10 bits (snooze).
- Edits to alarm_time made while ARMED take effect on the next compare.

## Timing
- A match present on the inputs at edge N gives state=10 and ring=1 from edge N.
- A stop, snooze or arm change sampled at edge N is reflected in state/ring at edge N.
- The disp and alarm_time update one cycle after set/inc/dec are sampled.
- Ring duration is exactly RING_SEC sec_ticks counted after entry. Snooze duration is exactly SNOOZE_SEC sec_ticks.
- A sec_tick on the same edge as the entry into a state is not counted.
- Reset asserted mid-ring or mid-snooze: all outputs return to reset values at the next edge. alarm_time is also lost.

## Test plan
- Reset: assert rst for 2 cycles → state=00, ring=0, alarm_time=0000, disp=alarm_ctrl_time (e.g. 1234) one cycle after rst drops with set=0.
- Edit wrap: set=1, sel=1, 25 inc pulses from 0000 → alarm_time=0100. Then sel=0, one dec pulse → 0159. inc+dec together → 0159 unchanged. disp=0159 while set=1.
- Trigger and timeout (RING_SEC=4): alarm 0700, arm=1, time 0659→0700 → state=10, ring=1. After 4 sec_ticks → state=01, ring=0, with no retrigger while time stays 0700. Time 0701 then back to 0700 → rings again.
- Snooze (SNOOZE_SEC=3): while ringing, snooze pulse → state=11, ring=0. After 3 sec_ticks → state=10, ring=1. A second snooze pulse in SNOOZE → no effect.
- Priority: stop and snooze in the same cycle during RINGING → state=01. arm=0 together with stop in SNOOZE → state=00.
- Reset mid-operation: rst during RINGING → state=00, ring=0, alarm_time=0000 at the next edge. No ring afterwards until re-armed and re-programmed.
